// File: rtl/rng_pkg.sv
// Shared types and helpers for the multi-channel LFSR random source.
package rng_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } fsm_e;

  localparam int unsigned MAX_W        = 64;
  localparam logic [31:0] DEF_TAP_MASK = 32'h8020_0003;
  localparam logic [31:0] DEF_SEED     = 32'hACE1_2469;

  // Fibonacci step on a zero-extended state: shift left, parity of tapped bits into LSB.
  function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] state,
                                                 input logic [MAX_W-1:0] mask);
    return {state[MAX_W-2:0], ^(state & mask)};
  endfunction

endpackage

// File: rtl/rng_out_slot.sv
// One output channel: holding register with valid/ready handshake and fresh tracking.
// RNG_RANGE_EN restricts captured values to below RANGE_MAX.
module rng_out_slot #(
  parameter int unsigned OUT_W     = 3,
  parameter int unsigned RANGE_MAX = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             i_flush,
  input  logic             i_run,
  input  logic             i_set_fresh,
  input  logic [OUT_W-1:0] i_slice,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [OUT_W-1:0] o_data
);

`ifdef RNG_RANGE_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic             r_valid;
  logic             r_fresh;
  logic [OUT_W-1:0] r_data;
  logic             w_take;
  logic             w_in_range;

  // An out-of-range slice still consumes the fresh flag so the channel waits for the next step.
  assign w_in_range = !RANGE_EN || (32'(i_slice) < RANGE_MAX);
  assign w_take     = i_run && r_fresh && (!r_valid || i_ready);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_valid <= 1'b0;
      r_fresh <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_fresh <= 1'b0;
    end else begin
      if (w_take && w_in_range) begin
        r_valid <= 1'b1;
        r_data  <= i_slice;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
      if (i_set_fresh) begin
        r_fresh <= 1'b1;
      end else if (w_take) begin
        r_fresh <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/lfsr_multi_rng.sv
// Multi-channel LFSR random source with reseed, warm-up discard and lockup recovery.
// Optional build macro RNG_RANGE_EN limits channel values to below RANGE_MAX.
module lfsr_multi_rng #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] TAP_MASK  = WIDTH'(rng_pkg::DEF_TAP_MASK),
  parameter logic [WIDTH-1:0] DEF_SEED  = WIDTH'(rng_pkg::DEF_SEED),
  parameter int unsigned      NUM_CH    = 2,
  parameter int unsigned      OUT_W     = 3,
  parameter int unsigned      WARM_CYC  = 4,
  parameter int unsigned      RANGE_MAX = 6
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [WIDTH-1:0]        seed,
  input  logic                    seed_load,
  input  logic                    step_en,
  input  logic [NUM_CH-1:0]       rd_ready,
  output logic [NUM_CH-1:0]       rd_valid,
  output logic [NUM_CH*OUT_W-1:0] rd_data,
  output logic                    busy,
  output logic                    lockup
);
  import rng_pkg::*;

  localparam int unsigned CNT_W = (WARM_CYC > 1) ? $clog2(WARM_CYC) : 1;

  fsm_e             r_fsm;
  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_seed_q;
  logic [CNT_W-1:0] r_warm_cnt;
  logic             r_lockup;

  logic [WIDTH-1:0] w_next;
  logic             w_zero;
  logic             w_in_run;
  logic             w_warm_done;
  logic             w_flush;
  logic             w_capture_en;
  logic             w_set_fresh;

  assign w_next      = WIDTH'(lfsr_next(64'(r_state), 64'(TAP_MASK)));
  assign w_zero      = (r_state == '0);
  assign w_in_run    = (r_fsm == RUN);
  assign w_warm_done = (r_warm_cnt == CNT_W'(WARM_CYC - 1));

  // Reseed and lockup recovery both discard anything the channels hold.
  assign w_flush      = seed_load || (r_fsm == LOAD) || (w_in_run && w_zero);
  assign w_capture_en = w_in_run && !w_zero && !seed_load;
  assign w_set_fresh  = !seed_load &&
                        ((w_capture_en && step_en) || ((r_fsm == WARMUP) && w_warm_done));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_fsm      <= WARMUP;
      r_state    <= DEF_SEED;
      r_seed_q   <= '0;
      r_warm_cnt <= '0;
      r_lockup   <= 1'b0;
    end else begin
      r_lockup <= 1'b0;
      if (seed_load) begin
        r_seed_q <= seed;
        r_fsm    <= LOAD;
      end else begin
        case (r_fsm)
          LOAD: begin
            r_state    <= (r_seed_q == '0) ? DEF_SEED : r_seed_q;
            r_warm_cnt <= '0;
            r_fsm      <= WARMUP;
          end
          WARMUP: begin
            r_state <= w_next;
            if (w_warm_done) begin
              r_warm_cnt <= '0;
              r_fsm      <= RUN;
            end else begin
              r_warm_cnt <= r_warm_cnt + CNT_W'(1);
            end
          end
          RUN: begin
            if (w_zero) begin
              r_state    <= DEF_SEED;
              r_lockup   <= 1'b1;
              r_warm_cnt <= '0;
              r_fsm      <= WARMUP;
            end else if (step_en) begin
              r_state <= w_next;
            end
          end
          default: r_fsm <= WARMUP;
        endcase
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rng_out_slot #(
      .OUT_W     (OUT_W),
      .RANGE_MAX (RANGE_MAX)
    ) u_slot (
      .Clk         (Clk),
      .Reset       (Reset),
      .i_flush     (w_flush),
      .i_run       (w_capture_en),
      .i_set_fresh (w_set_fresh),
      .i_slice     (r_state[i*OUT_W +: OUT_W]),
      .i_ready     (rd_ready[i]),
      .o_valid     (rd_valid[i]),
      .o_data      (rd_data[i*OUT_W +: OUT_W])
    );
  end

  assign busy   = !w_in_run;
  assign lockup = r_lockup;

endmodule

// File: tb/tb_lfsr_multi_rng.sv
// Testbench for lfsr_multi_rng: directed sequence with random seeds/handshakes against a value-stream model.
module tb_lfsr_multi_rng;

  localparam logic [31:0] DEF_SEED = 32'hACE1_2469;
  localparam logic [31:0] DEF_MASK = 32'h8020_0003;
`ifdef RNG_RANGE_EN
  localparam bit TB_RANGE = 1'b1;
`else
  localparam bit TB_RANGE = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] seed = '0;
  logic        seed_load = 1'b0;
  logic        step_en = 1'b0;
  logic [1:0]  rd_ready = '0;
  logic [1:0]  rd_valid;
  logic [5:0]  rd_data;
  logic        busy;
  logic        lockup;

  logic [31:0] z_seed = '0;
  logic        z_seed_load = 1'b0;
  logic        z_step = 1'b0;
  logic [1:0]  z_ready = '0;
  logic [1:0]  z_valid;
  logic [5:0]  z_data;
  logic        z_busy;
  logic        z_lockup;

  int total = 0;
  int bad   = 0;

  // Model: current LFSR value, per-channel "new value available", delivered value/valid.
  logic [31:0] m_state;
  bit   [1:0]  m_pend;
  bit   [1:0]  m_v;
  logic [2:0]  m_d [2];
  logic [5:0]  first_val;

  always #5 Clk = ~Clk;

  lfsr_multi_rng dut (
    .Clk(Clk), .Reset(Reset), .seed(seed), .seed_load(seed_load), .step_en(step_en),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .lockup(lockup)
  );

  lfsr_multi_rng #(.TAP_MASK(32'h0)) dut_z (
    .Clk(Clk), .Reset(Reset), .seed(z_seed), .seed_load(z_seed_load), .step_en(z_step),
    .rd_ready(z_ready), .rd_valid(z_valid), .rd_data(z_data), .busy(z_busy), .lockup(z_lockup)
  );

  function automatic logic [31:0] nxt(input logic [31:0] s, input logic [31:0] mask);
    return (s << 1) | 32'($countones(s & mask) % 2);
  endfunction

  function automatic logic [31:0] adv(input logic [31:0] s, input logic [31:0] mask, input int n);
    logic [31:0] r;
    r = s;
    for (int k = 0; k < n; k++) r = nxt(r, mask);
    return r;
  endfunction

  function automatic bit in_range(input logic [2:0] v);
    return !TB_RANGE || (v < 3'd6);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_load(input logic [31:0] base);
    m_state = adv(base, DEF_MASK, 4);
    m_pend  = 2'b11;
    m_v     = 2'b00;
  endtask

  // One RUN cycle: each channel hands out the value present when it becomes free, once per step.
  task automatic model_edge(input bit step, input logic [1:0] ready);
    for (int i = 0; i < 2; i++) begin
      logic [2:0] sl;
      sl = 3'((m_state >> (3 * i)) & 32'h7);
      if (m_pend[i] && (!m_v[i] || ready[i])) begin
        if (in_range(sl)) begin
          m_v[i] = 1'b1;
          m_d[i] = sl;
        end else begin
          m_v[i] = m_v[i] & ~ready[i];
        end
        m_pend[i] = 1'b0;
      end else if (m_v[i] && ready[i]) begin
        m_v[i] = 1'b0;
      end
      if (step) m_pend[i] = 1'b1;
    end
    if (step) m_state = nxt(m_state, DEF_MASK);
  endtask

  task automatic run_edge(input bit step, input logic [1:0] ready);
    step_en  = step;
    rd_ready = ready;
    tick();
    model_edge(step, ready);
    chk("run_valid", 64'(rd_valid), 64'(m_v));
    chk("run_data", 64'(rd_data), 64'({m_d[1], m_d[0]}));
    chk("run_lockup", 64'(lockup), 64'(0));
    if (TB_RANGE) begin
      if (rd_valid[0]) chk("range_ch0", 64'(rd_data[2:0] < 3'd6), 64'(1));
      if (rd_valid[1]) chk("range_ch1", 64'(rd_data[5:3] < 3'd6), 64'(1));
    end
  endtask

  task automatic do_load(input logic [31:0] s, input bit step, input logic [1:0] ready);
    logic [31:0] base;
    seed      = s;
    seed_load = 1'b1;
    step_en   = step;
    rd_ready  = ready;
    tick();
    chk("load_valid", 64'(rd_valid), 64'(0));
    chk("load_busy", 64'(busy), 64'(1));
    seed_load = 1'b0;
    step_en   = 1'b0;
    rd_ready  = 2'b00;
    base = (s == 32'h0) ? DEF_SEED : s;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("warm_state", 64'(dut.r_state), 64'(adv(base, DEF_MASK, k - 1)));
      chk("warm_busy", 64'(busy), 64'(k < 5));
    end
    model_load(base);
  endtask

  initial begin
    m_d[0] = '0;
    m_d[1] = '0;
    // Reset values
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'(1));
    chk("rst_valid", 64'(rd_valid), 64'(0));
    chk("rst_data", 64'(rd_data), 64'(0));
    chk("rst_lockup", 64'(lockup), 64'(0));
    chk("rst_state", 64'(dut.r_state), 64'(DEF_SEED));
    Reset = 1'b0;

    // Warm-up after reset, first capture on the 5th edge, then held with ready low
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("wu_busy", 64'(busy), 64'(k < 4));
      chk("wu_valid", 64'(rd_valid), 64'(0));
    end
    model_load(DEF_SEED);
    run_edge(1'b0, 2'b00);
    chk("first_valid", 64'(rd_valid), 64'(2'b11));
    first_val = {m_d[1], m_d[0]};
    for (int k = 0; k < 20; k++) begin
      run_edge(bit'($urandom_range(0, 1)), 2'b00);
      chk("hold_data", 64'(rd_data), 64'(first_val));
    end

    // ch0 drains every step, ch1 keeps its first value
    for (int k = 0; k < 16; k++) begin
      run_edge(1'b1, 2'b01);
      chk("ch1_hold", 64'(rd_data[5:3]), 64'(first_val[5:3]));
    end

    // seed_load beats a simultaneous step and capture; seed=1 stream
    do_load(32'h1, 1'b1, 2'b11);
    run_edge(1'b0, 2'b11);
    chk("seed1_data", 64'(rd_data), 64'(6'o33));
    run_edge(1'b0, 2'b11);
    chk("consume_drop", 64'(rd_valid), 64'(0));

    // seed_load in the middle of warm-up restarts it; zero seed falls back to the default
    seed      = $urandom;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    tick();
    tick();
    chk("wu_restart_busy", 64'(busy), 64'(1));
    do_load(32'h0, 1'b0, 2'b00);
    run_edge(1'b0, 2'b00);
    chk("zero_seed_data", 64'(rd_data), 64'(first_val));

    // Random seeds with random step/ready patterns
    for (int it = 0; it < 4; it++) begin
      do_load($urandom, 1'b0, 2'b00);
      for (int k = 0; k < 30; k++)
        run_edge(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end
    if (TB_RANGE) begin
      for (int k = 0; k < 1200; k++) run_edge(1'b1, 2'b11);
    end

    // Zero tap mask drives the state to zero in RUN: one lockup pulse then warm-up again
    z_seed      = 32'h1;
    z_seed_load = 1'b1;
    z_step      = 1'b1;
    z_ready     = 2'b11;
    tick();
    z_seed_load = 1'b0;
    for (int n = 1; n <= 38; n++) begin
      tick();
      chk("z_lockup", 64'(z_lockup), 64'(n == 34));
      if (n == 34) begin
        chk("z_reload", 64'(dut_z.r_state), 64'(DEF_SEED));
        chk("z_busy", 64'(z_busy), 64'(1));
        chk("z_flush", 64'(z_valid), 64'(0));
      end
    end
    chk("z_rewarm_busy", 64'(z_busy), 64'(0));
    chk("z_rewarm_state", 64'(dut_z.r_state), 64'(adv(DEF_SEED, 32'h0, 4)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_multi_rng.md
Name: lfsr_multi_rng

Overview:
- Parametrised multi-channel pseudo-random source for the game's spawn logic: lane position, car count and colour.
- One Fibonacci LFSR core: shift-left, feedback into LSB.
- Each of NUM_CH independent consumers gets an OUT_W-bit value over a valid/ready handshake. A value is never delivered twice.
- Adds runtime reseed, zero-seed protection, warm-up discard and lockup recovery.

Parameters:
WIDTH, 32, LFSR state width (8..64)
TAP_MASK, 32'h8020_0003, feedback mask; bit k set means state[k] feeds the XOR (default: bits 31, 21, 1, 0)
DEF_SEED, 32'hACE1_2469, nonzero fallback seed used at reset, on zero seed and on lockup
NUM_CH, 2, output channels; NUM_CH*OUT_W must be <= WIDTH
OUT_W, 3, bits per channel value
WARM_CYC, 4, LFSR steps discarded after reset or load (>=1)
RANGE_MAX, 6, exclusive upper bound on channel values (RNG_RANGE_EN only)

Ports:
Clk  in  1  clock
Reset  in  1  asynchronous, active-high reset
seed  in  WIDTH  seed value, sampled when seed_load=1
seed_load  in  1  single-cycle request to reseed
step_en  in  1  advance the LFSR in RUN (game tick)
rd_ready  in  NUM_CH  per-channel consumer ready
rd_valid  out  NUM_CH  per-channel value valid
rd_data  out  NUM_CH*OUT_W  channel i value at [i*OUT_W +: OUT_W]
busy  out  1  high whenever FSM is not RUN
lockup  out  1  one-cycle pulse when all-zero state is recovered

Behaviour:
- Step: next = {state[WIDTH-2:0], ^(state & TAP_MASK)}.
- FSM states: LOAD, WARMUP, RUN.
- Reset (async): state=DEF_SEED, FSM=WARMUP, warm_cnt=0, rd_valid=0, rd_data=0, fresh=0, lockup=0. busy=1.
- WARMUP:
  - Steps every cycle regardless of step_en; warm_cnt increments.
  - When warm_cnt==WARM_CYC-1, go to RUN and set fresh[all]=1.
- LOAD (one cycle):
  - state = (seed==0) ? DEF_SEED : seed, using the seed captured when seed_load was sampled.
  - rd_valid[all]=0, fresh=0, warm_cnt=0, then go to WARMUP.
- RUN:
  - LFSR steps when step_en=1 and sets fresh[all]=1.
- Channel i capture: when FSM=RUN, fresh[i]=1 and (!rd_valid[i] | rd_ready[i]):
  - rd_data slice i = state[i*OUT_W +: OUT_W] (pre-step value).
  - rd_valid[i]=1 and fresh[i] is cleared.
  - If a step and a capture happen in the same cycle, fresh[i] ends at 1.
- Consume without capture: rd_valid[i] & rd_ready[i] with no capture drops rd_valid[i] to 0.
- Stability: rd_data[i] is held stable while rd_valid[i]=1 and rd_ready[i]=0.
- Latency: first rd_valid rises on the (WARM_CYC+1)th rising edge after Reset release. After that, one value per channel per step.
- seed_load:
  - Accepted in any state; highest priority; it overrides a step and a capture in the same cycle.
  - Next state is LOAD. A seed_load during WARMUP restarts warm-up.
- Lockup: in RUN, if state==0, reload DEF_SEED, pulse lockup for one cycle, go to WARMUP and flush rd_valid.
- busy = (FSM != RUN).

Optional Feature:
- RNG_RANGE_EN defined:
  - A channel captures only if its slice value < RANGE_MAX.
  - If the slice is out of range, fresh[i] is cleared without capture and the channel waits for the next step.
  - rd_data never reaches RANGE_MAX..2^OUT_W-1.
- Undefined: all 2^OUT_W values pass and RANGE_MAX is ignored.

Decomposition:
- Package rng_pkg holds:
  - fsm state enum (LOAD, WARMUP, RUN)
  - default constants DEF_TAP_MASK and DEF_SEED
  - function lfsr_next(state, mask)
- Sub-module rng_out_slot, instantiated NUM_CH times: one channel holding register with the valid/ready and fresh logic.
- Top holds the LFSR core and the FSM.

Test Plan:
- Reset, defaults, rd_ready=0 -> busy=1 for 4 cycles; rd_valid=2'b11 after the 5th edge; data then held constant for 20 cycles.
- seed_load with seed=1, WARM_CYC=4 -> state sequence 1, 3, 6, 0xD, 0x1B; ch0=3, ch1=3 on first capture.
- seed_load with seed=0 -> state=DEF_SEED 0xACE12469, same output stream as after Reset.
- step_en every cycle, rd_ready[0]=1 and rd_ready[1]=0 -> ch0 delivers a new slice each step; ch1 holds its first value; no value is duplicated on ch0.
- seed_load asserted in the same cycle as step_en and rd_ready=1 -> no capture, rd_valid=0 next cycle, busy=1.
- TAP_MASK=0 (forces zero state), seed=1 -> state reaches 0 in RUN; lockup pulses once; DEF_SEED reloaded; warm-up replayed.
- RNG_RANGE_EN, OUT_W=3, RANGE_MAX=6 -> over 1000 captures, rd_data is never 6 or 7.
